// File: rtl/dsm_pkg.sv
// Shared constants and helpers for the MASH delta-sigma DAC: dither LFSR constants,
// order clamping and the per-stage noise-cancellation term.
package dsm_pkg;

  localparam int MAX_STAGES = 4;
  localparam int TERM_W     = 8;

  // Galois LFSR, right shifting; low LFSR_W bits are used by the modulator.
  localparam logic [31:0] LFSR_POLY = 32'h0000_B400;
  localparam logic [31:0] LFSR_SEED = 32'h0000_ACE1;

  function automatic logic [2:0] clamp_order(input logic [2:0] cfg, input int stages);
    if (cfg == 3'd0 || int'(cfg) > stages) return 3'(stages);
    return cfg;
  endfunction

  // Stage k (0-based) contributes (1 - z^-1)^k applied to its carry history.
  function automatic logic signed [TERM_W-1:0] cancel_term(
    input int   k,
    input logic c0,
    input logic c1,
    input logic c2,
    input logic c3
  );
    logic signed [TERM_W-1:0] t0, t1, t2, t3;
    t0 = {{(TERM_W-1){1'b0}}, c0};
    t1 = {{(TERM_W-1){1'b0}}, c1};
    t2 = {{(TERM_W-1){1'b0}}, c2};
    t3 = {{(TERM_W-1){1'b0}}, c3};
    case (k)
      0:       return t0;
      1:       return t0 - t1;
      2:       return t0 - t1 - t1 + t2;
      3:       return t0 - t1 - t1 - t1 + t2 + t2 + t2 - t3;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/dsm_acc_stage.sv
// One first-order accumulator stage: adds its input to the running sum and
// emits the overflow as a one-bit carry.
module dsm_acc_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] addend,
  input  logic             lsb_add,
  output logic [WIDTH-1:0] acc_next,
  output logic             carry
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, addend} + {{WIDTH{1'b0}}, lsb_add};
    acc_next = en ? sum[WIDTH-1:0] : '0;
  end

  // A disabled stage is held at zero so it rejoins later from a clean state.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      acc   <= '0;
      carry <= 1'b0;
    end else begin
      {carry, acc} <= sum;
    end
  end

endmodule

// File: rtl/axis_mash_dsm_dac.sv
// MASH 1-1(-1..) delta-sigma DAC modulator with run-time order select, LFSR dither,
// OSR-paced AXIS sample acceptance and sticky underrun detection.
module axis_mash_dsm_dac
  import dsm_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int STAGES = 2,
  parameter  int OSR    = 64,
  parameter  int LFSR_W = 16,
  localparam int OUT_W  = STAGES + 1
) (
  input  logic                    aclk,
  input  logic                    arst,
  input  logic signed [WIDTH-1:0] s_axis_data_tdata,
  input  logic                    s_axis_data_tvalid,
  output logic                    s_axis_data_tready,
  input  logic [2:0]              cfg_order,
  input  logic                    cfg_dither_en,
  output logic signed [OUT_W-1:0] m_axis_data_tdata,
  output logic                    m_axis_data_tvalid,
  output logic                    underrun
);

  localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;

  logic [CNT_W-1:0]         osr_cnt;
  logic signed [WIDTH-1:0]  sample_reg, sample_eff;
  logic [2:0]               order_reg, order_eff;
  logic                     dither_reg, dither_eff;
  logic [LFSR_W-1:0]        lfsr;
  logic [WIDTH-1:0]         u;
  logic [STAGES-1:0]        stage_en, carry, dly1, dly2, dly3;
  logic [WIDTH-1:0]         acc_next [STAGES];
  logic signed [TERM_W-1:0] y_sum;
  logic                     unused_tail;

  // On a strobe the new sample, order and dither setting drive this very update.
  always_comb begin
    sample_eff = sample_reg;
    order_eff  = order_reg;
    dither_eff = dither_reg;
    if (s_axis_data_tready) begin
      if (s_axis_data_tvalid) sample_eff = s_axis_data_tdata;
      order_eff  = clamp_order(cfg_order, STAGES);
      dither_eff = cfg_dither_en;
    end
    u = {~sample_eff[WIDTH-1], sample_eff[WIDTH-2:0]};
    for (int k = 0; k < STAGES; k++) stage_en[k] = (k < int'(order_eff));
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] addend;
    logic             lsb_add;
    if (k == 0) begin : g_first
      assign addend  = u;
      assign lsb_add = lfsr[0] & dither_eff;
    end else begin : g_next
      assign addend  = acc_next[k-1];
      assign lsb_add = 1'b0;
    end
    dsm_acc_stage #(.WIDTH(WIDTH)) u_acc (
      .clk      (aclk),
      .rst      (arst),
      .en       (stage_en[k]),
      .addend   (addend),
      .lsb_add  (lsb_add),
      .acc_next (acc_next[k]),
      .carry    (carry[k])
    );
  end

  assign unused_tail = ^acc_next[STAGES-1];

  always_comb begin
    y_sum = '0;
    for (int k = 0; k < STAGES; k++)
      y_sum = y_sum + cancel_term(k, carry[k], dly1[k], dly2[k], dly3[k]);
  end

  // Carry delay lines of disabled stages clear together with their accumulators.
  always_ff @(posedge aclk) begin
    if (arst) begin
      osr_cnt            <= '0;
      s_axis_data_tready <= 1'b0;
      sample_reg         <= '0;
      order_reg          <= clamp_order(3'd0, STAGES);
      dither_reg         <= 1'b0;
      lfsr               <= LFSR_SEED[LFSR_W-1:0];
      dly1               <= '0;
      dly2               <= '0;
      dly3               <= '0;
      m_axis_data_tdata  <= '0;
      m_axis_data_tvalid <= 1'b0;
      underrun           <= 1'b0;
    end else begin
      osr_cnt            <= (osr_cnt == CNT_W'(OSR - 1)) ? '0 : osr_cnt + CNT_W'(1);
      s_axis_data_tready <= (osr_cnt == CNT_W'(OSR - 1));
      sample_reg         <= sample_eff;
      order_reg          <= order_eff;
      dither_reg         <= dither_eff;
      if (s_axis_data_tready && !s_axis_data_tvalid) underrun <= 1'b1;
      lfsr               <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_POLY[LFSR_W-1:0] : '0);
      dly1               <= carry & stage_en;
      dly2               <= dly1 & stage_en;
      dly3               <= dly2 & stage_en;
      m_axis_data_tdata  <= y_sum[OUT_W-1:0];
      m_axis_data_tvalid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_mash_dsm_dac.sv
// Self-checking bench for axis_mash_dsm_dac: directed table, hand sequences, NCO sine
// and randomized traffic, all compared against an arithmetic reference model.
module tb_axis_mash_dsm_dac;
  import dsm_pkg::*;

  localparam int WIDTH  = 16;
  localparam int STAGES = 2;
  localparam int OSR    = 64;
  localparam int LFSR_W = 16;
  localparam int OUT_W  = STAGES + 1;
  localparam int NS     = 512;
  localparam int unsigned NCO_STEP = 32'd41943040;

  logic                    aclk = 1'b0;
  logic                    arst = 1'b1;
  logic signed [WIDTH-1:0] s_tdata = '0;
  logic                    s_tvalid = 1'b1;
  logic                    s_tready;
  logic [2:0]              cfg_order = 3'd2;
  logic                    cfg_dither_en = 1'b0;
  logic signed [OUT_W-1:0] m_tdata;
  logic                    m_tvalid;
  logic                    underrun;

  always #5 aclk = ~aclk;

  axis_mash_dsm_dac #(.WIDTH(WIDTH), .STAGES(STAGES), .OSR(OSR), .LFSR_W(LFSR_W)) dut (
    .aclk               (aclk),
    .arst               (arst),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .cfg_order          (cfg_order),
    .cfg_dither_en      (cfg_dither_en),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .underrun           (underrun)
  );

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  // Reference model: integer accumulators and carry histories per stage.
  int          m_sample, m_order, m_dither, m_cnt, m_ready, m_valid, m_underrun, m_out;
  int unsigned m_lfsr;
  int          m_acc  [MAX_STAGES];
  int          m_hist [MAX_STAGES][MAX_STAGES];

  typedef struct {
    int tdata;
    int order;
    int dither;
    int lo;
    int hi;
    int sum;
    int tol;
  } row_t;

  row_t rows [9];

  function automatic int binom(input int n, input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic void model_reset();
    m_sample = 0; m_order = STAGES; m_dither = 0; m_cnt = 0; m_ready = 0;
    m_valid = 0; m_underrun = 0; m_out = 0; m_lfsr = LFSR_SEED & 32'h0000_FFFF;
    for (int k = 0; k < MAX_STAGES; k++) begin
      m_acc[k] = 0;
      for (int j = 0; j < MAX_STAGES; j++) m_hist[k][j] = 0;
    end
  endfunction

  function automatic void model_edge();
    int val, tot;
    if (arst) begin
      model_reset();
      return;
    end
    m_out = 0;
    for (int k = 0; k < STAGES; k++)
      for (int j = 0; j <= k; j++)
        m_out += ((j % 2) ? -1 : 1) * binom(k, j) * m_hist[k][j];
    if (m_ready != 0) begin
      if (s_tvalid) m_sample = int'(s_tdata);
      else          m_underrun = 1;
      m_order  = (cfg_order == 3'd0 || int'(cfg_order) > STAGES) ? STAGES : int'(cfg_order);
      m_dither = int'(cfg_dither_en);
    end
    val = m_sample + 32768 + (m_dither & int'(m_lfsr & 1));
    if ((m_lfsr & 1) != 0) m_lfsr = (m_lfsr >> 1) ^ (LFSR_POLY & 32'h0000_FFFF);
    else                   m_lfsr = m_lfsr >> 1;
    for (int k = 0; k < STAGES; k++) begin
      if (k < m_order) begin
        for (int j = MAX_STAGES - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
        tot          = m_acc[k] + val;
        m_hist[k][0] = tot / 65536;
        m_acc[k]     = tot % 65536;
        val          = m_acc[k];
      end else begin
        m_acc[k] = 0;
        for (int j = 0; j < MAX_STAGES; j++) m_hist[k][j] = 0;
      end
    end
    m_ready = (m_cnt == OSR - 1) ? 1 : 0;
    m_cnt   = (m_cnt + 1) % OSR;
    m_valid = 1;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      if (failures <= 40)
        $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      failures++;
      if (failures <= 40)
        $display("[TB] FAIL %s: got %0d, expected %0d..%0d at %0t", name, actual, lo, hi, $time);
    end
  endtask

  task automatic check_near(input string name, input real actual, input real expected, input real tol);
    real diff;
    diff = actual - expected;
    if (diff < 0.0) diff = -diff;
    checks++;
    if (diff >= tol) begin
      failures++;
      if (failures <= 40)
        $display("[TB] FAIL %s: got %f, expected %f within %f at %0t", name, actual, expected, tol, $time);
    end
  endtask

  task automatic apply_stimulus(input bit valid, input int data, input int order, input bit dither);
    s_tvalid      = valid;
    s_tdata       = 16'(data);
    cfg_order     = 3'(order);
    cfg_dither_en = dither;
  endtask

  task automatic tick();
    model_edge();
    if (arst) edge_cnt = 0;
    else      edge_cnt++;
    @(posedge aclk);
    #1;
    check_output("out_data",  int'(m_tdata), m_out);
    check_output("out_valid", int'(m_tvalid), m_valid);
    check_output("tready",    int'(s_tready), m_ready);
    check_output("underrun",  int'(underrun), m_underrun);
  endtask

  task automatic do_reset(input int n);
    arst = 1'b1;
    for (int i = 0; i < n; i++) begin
      s_tdata = 16'($urandom);
      tick();
      check_output("rst_tdata",    int'(m_tdata), 0);
      check_output("rst_tvalid",   int'(m_tvalid), 0);
      check_output("rst_tready",   int'(s_tready), 0);
      check_output("rst_underrun", int'(underrun), 0);
    end
    arst = 1'b0;
  endtask

  // Advance until the next clock edge is a strobe edge.
  task automatic wait_strobe();
    for (int i = 0; i <= OSR && m_ready == 0; i++) tick();
    if (m_ready == 0) check_output("strobe_timeout", 0, 1);
  endtask

  initial begin
    int first, sum, mn, mx, cur_u, expect_bit;
    int unsigned phase;
    real angle;

    rows[0] = '{-32768, 2, 0,  0, 0,    0, 0};
    rows[1] = '{     0, 1, 0,  0, 1,  512, 1};
    rows[2] = '{     0, 2, 0, -1, 2,  512, 2};
    rows[3] = '{ 16384, 1, 0,  0, 1,  768, 1};
    rows[4] = '{-16384, 2, 0, -1, 2,  256, 2};
    rows[5] = '{     0, 0, 0, -1, 2,  512, 2};
    rows[6] = '{     0, 7, 0, -1, 2,  512, 2};
    rows[7] = '{  8192, 2, 1, -1, 2,  640, 3};
    rows[8] = '{ 32767, 1, 0,  0, 1, 1024, 1};

    model_reset();
    $display("[TB] reset and first strobe timing");
    apply_stimulus(1'b1, 0, 2, 1'b0);
    do_reset(5);
    first = -1;
    for (int i = 1; i <= OSR + 8; i++) begin
      tick();
      if (i == 1) check_output("tvalid_after_release", int'(m_tvalid), 1);
      if (s_tready && first < 0) first = i;
    end
    check_output("first_tready_edge", first, OSR);

    $display("[TB] constant-input table");
    for (int r = 0; r < 9; r++) begin
      do_reset(2);
      apply_stimulus(1'b1, rows[r].tdata, rows[r].order, rows[r].dither[0]);
      wait_strobe();
      tick();
      repeat (3) tick();
      sum = 0; mn = 100; mx = -100;
      for (int i = 0; i < 1024; i++) begin
        tick();
        sum += int'(m_tdata);
        if (int'(m_tdata) < mn) mn = int'(m_tdata);
        if (int'(m_tdata) > mx) mx = int'(m_tdata);
      end
      check_range($sformatf("row%0d_sum", r), sum, rows[r].sum - rows[r].tol, rows[r].sum + rows[r].tol);
      check_range($sformatf("row%0d_min", r), mn, rows[r].lo, rows[r].hi);
      check_range($sformatf("row%0d_max", r), mx, rows[r].lo, rows[r].hi);
      check_output($sformatf("row%0d_no_underrun", r), int'(underrun), 0);
    end

    $display("[TB] midscale order 1 alternation");
    do_reset(2);
    apply_stimulus(1'b1, 0, 1, 1'b0);
    wait_strobe();
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      expect_bit = edge_cnt % 2;
      check_output("alt_order1", int'(m_tdata), expect_bit);
    end

    $display("[TB] underrun hold and stickiness");
    do_reset(2);
    apply_stimulus(1'b1, 16384, 2, 1'b0);
    wait_strobe();
    tick();
    wait_strobe();
    apply_stimulus(1'b0, -32768, 2, 1'b0);
    tick();
    s_tvalid = 1'b1;
    sum = 0;
    for (int j = 1; j <= OSR; j++) begin
      tick();
      sum += int'(m_tdata);
    end
    check_range("underrun_held_sum", sum, 46, 50);
    check_output("underrun_set", int'(underrun), 1);
    repeat (2 * OSR) tick();
    check_output("underrun_sticky", int'(underrun), 1);

    $display("[TB] order change 2 to 1");
    do_reset(2);
    apply_stimulus(1'b1, 5000, 2, 1'b0);
    wait_strobe();
    tick();
    repeat (100) tick();
    wait_strobe();
    cfg_order = 3'd1;
    tick();
    for (int i = 0; i < 32; i++) begin
      tick();
      check_range("order1_range", int'(m_tdata), 0, 1);
    end

    $display("[TB] randomized traffic with mid-run reset");
    do_reset(2);
    for (int n = 0; n < 150 * OSR; n++) begin
      s_tdata = 16'($urandom);
      if (m_ready != 0) begin
        s_tvalid      = ($urandom_range(0, 15) != 0);
        cfg_order     = 3'($urandom_range(0, 7));
        cfg_dither_en = 1'($urandom_range(0, 1));
      end else begin
        s_tvalid = 1'($urandom_range(0, 1));
      end
      if (n == 75 * OSR + 17) begin
        arst = 1'b1;
        tick();
        arst = 1'b0;
        check_output("midrst_tdata",    int'(m_tdata), 0);
        check_output("midrst_tvalid",   int'(m_tvalid), 0);
        check_output("midrst_tready",   int'(s_tready), 0);
        check_output("midrst_underrun", int'(underrun), 0);
      end else begin
        tick();
      end
    end

    $display("[TB] NCO sine, order 2");
    do_reset(2);
    phase = 0;
    apply_stimulus(1'b1, 0, 2, 1'b0);
    wait_strobe();
    tick();
    cur_u = int'(s_tdata) + 32768;
    for (int i = 0; i < NS; i++) begin
      sum = 0;
      for (int j = 1; j <= OSR; j++) begin
        if (j == OSR) begin
          phase  += NCO_STEP;
          angle   = real'(phase) / 4294967296.0 * 6.283185307179586;
          s_tdata = 16'(int'(30000.0 * $sin(angle)));
        end
        tick();
        sum += int'(m_tdata);
      end
      // Over one sample period the carry sums deviate from OSR*u/2^16 by less than 2.
      check_near("sine_avg", real'(sum), real'(OSR) * real'(cur_u) / 65536.0, 2.0);
      cur_u = int'(s_tdata) + 32768;
    end
    check_output("sine_no_underrun", int'(underrun), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
